// File: rtl/matadj3_pkg.sv
// matadj3_pkg
//   Shared types and constants for the sequential 3x3 adjugate/determinant
//   engine (matadj3_seq) and its cofactor index table (matadj3_idx_lut).
//
//   Contents:
//     state_t     - controller states IDLE -> COF -> DET -> OUT
//     COF_CYCLES  - cycles spent walking the nine cofactors (two each)
//     DET_CYCLES  - cycles spent accumulating the determinant
//     NUM_ELEMS   - element count of a 3x3 matrix
//     IDX_W       - width of a flat element index (0..8)
//     cof_sel_t   - operand/destination selection for one cofactor
//     elem_idx    - flat index of element (r,c), i.e. 3r+c
package matadj3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COF,
        DET,
        OUT
    } state_t;

    localparam int COF_CYCLES = 18;
    localparam int DET_CYCLES = 3;
    localparam int NUM_ELEMS  = 9;
    localparam int IDX_W      = 4;

    // One cofactor C(r,c) is a[r1][c1]*a[r2][c2] - a[r1][c2]*a[r2][c1],
    // negated when r+c is odd, and lands at adjugate element (c,r).
    typedef struct packed {
        logic [IDX_W-1:0] idxP0;
        logic [IDX_W-1:0] idxP1;
        logic [IDX_W-1:0] idxQ0;
        logic [IDX_W-1:0] idxQ1;
        logic [IDX_W-1:0] idxDst;
        logic             neg;
    } cof_sel_t;

    function automatic logic [IDX_W-1:0] elem_idx(input logic [1:0] r,
                                                   input logic [1:0] c);
        return IDX_W'(r) * IDX_W'(3) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/matadj3_idx_lut.sv
// matadj3_idx_lut
//   Combinational table mapping a cofactor number k (0..8, row-major over
//   the 3x3 matrix) to the four element indices feeding the 2x2 minor,
//   the transposed destination index in the adjugate, and the sign bit.
//   Keeping this here leaves the sequencer datapath free of index math.
//
//   Ports:
//     k_i    input  [3:0]     cofactor number, r = k/3, c = k%3
//     sel_o  output cof_sel_t operand indices, destination index, sign
module matadj3_idx_lut
    import matadj3_pkg::*;
(
    input  logic [3:0] k_i,
    output cof_sel_t   sel_o
);

    logic [1:0] rowSel;
    logic [1:0] colSel;
    logic [1:0] rowLo;
    logic [1:0] rowHi;
    logic [1:0] colLo;
    logic [1:0] colHi;

    // Split the cofactor number into its row and column. Values above 8
    // never occur while cofactors are being walked; they fold to (0,0).
    always_comb begin
        rowSel = 2'd0;
        colSel = 2'd0;
        case (k_i)
            4'd0:    begin rowSel = 2'd0; colSel = 2'd0; end
            4'd1:    begin rowSel = 2'd0; colSel = 2'd1; end
            4'd2:    begin rowSel = 2'd0; colSel = 2'd2; end
            4'd3:    begin rowSel = 2'd1; colSel = 2'd0; end
            4'd4:    begin rowSel = 2'd1; colSel = 2'd1; end
            4'd5:    begin rowSel = 2'd1; colSel = 2'd2; end
            4'd6:    begin rowSel = 2'd2; colSel = 2'd0; end
            4'd7:    begin rowSel = 2'd2; colSel = 2'd1; end
            4'd8:    begin rowSel = 2'd2; colSel = 2'd2; end
            default: begin rowSel = 2'd0; colSel = 2'd0; end
        endcase
    end

    // The minor uses the two rows and two columns not crossed out,
    // kept in ascending order so the product pairing matches the
    // a[r1][c1]*a[r2][c2] - a[r1][c2]*a[r2][c1] form.
    always_comb begin
        rowLo = 2'd1;
        rowHi = 2'd2;
        colLo = 2'd1;
        colHi = 2'd2;
        case (rowSel)
            2'd0:    begin rowLo = 2'd1; rowHi = 2'd2; end
            2'd1:    begin rowLo = 2'd0; rowHi = 2'd2; end
            default: begin rowLo = 2'd0; rowHi = 2'd1; end
        endcase
        case (colSel)
            2'd0:    begin colLo = 2'd1; colHi = 2'd2; end
            2'd1:    begin colLo = 2'd0; colHi = 2'd2; end
            default: begin colLo = 2'd0; colHi = 2'd1; end
        endcase
    end

    // Assemble the flat indices; the destination is transposed because
    // the adjugate is the transpose of the cofactor matrix.
    always_comb begin
        sel_o.idxP0  = elem_idx(rowLo, colLo);
        sel_o.idxP1  = elem_idx(rowHi, colHi);
        sel_o.idxQ0  = elem_idx(rowLo, colHi);
        sel_o.idxQ1  = elem_idx(rowHi, colLo);
        sel_o.idxDst = elem_idx(colSel, rowSel);
        sel_o.neg    = rowSel[0] ^ colSel[0];
    end

endmodule

// File: rtl/matadj3_seq.sv
// matadj3_seq
//   Sequential 3x3 adjugate and determinant engine. A single DATA_WIDTH
//   multiplier is time-shared: 18 cycles walk the nine cofactors (two
//   products each), 3 cycles accumulate det = a00*C00 + a01*C01 + a02*C02,
//   then the result is presented with a valid/ready handshake. All
//   arithmetic is two's complement modulo 2^DATA_WIDTH; products are
//   truncated and wrap-around is silent.
//
//   Optional feature macro: MATADJ3_SINGULAR_EN
//     defined   - adds the singular output (det==0) and zeroes adj when set
//     undefined - no singular port, adj is presented unmodified
//
//   Ports:
//     clk        input   1      clock, rising edge
//     rst_n      input   1      synchronous active-low reset
//     in_valid   input   1      matrix a is valid
//     in_ready   output  1      block accepts a (high only in IDLE)
//     a          input   9*DW   element (r,c) at [(3r+c)*DW +: DW]
//     out_valid  output  1      adj/det are valid
//     out_ready  input   1      consumer accepts the result
//     adj        output  9*DW   adjugate, same packing as a
//     det        output  DW     determinant
//     singular   output  1      det==0 (only with MATADJ3_SINGULAR_EN)
module matadj3_seq
    import matadj3_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] adj,
    output logic [DATA_WIDTH-1:0]             det
`ifdef MATADJ3_SINGULAR_EN
    ,
    output logic                              singular
`endif
);

    localparam int CNT_W = 5;

    if (MATRIX_SIZE != NUM_ELEMS) begin : gSizeCheck
        $error("matadj3_seq: MATRIX_SIZE must be 9");
    end

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] mat_q, mat_d;
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] cof_q, cof_d;
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] adj_q, adj_d;
    logic [DATA_WIDTH-1:0]                part_q, part_d;
    logic [DATA_WIDTH-1:0]                acc_q, acc_d;
    logic [DATA_WIDTH-1:0]                det_q, det_d;
`ifdef MATADJ3_SINGULAR_EN
    logic                                 sing_q, sing_d;
`endif

    cof_sel_t              cofSel;
    logic [3:0]            cofK;
    logic [1:0]            detIdx;
    logic [DATA_WIDTH-1:0] mulA;
    logic [DATA_WIDTH-1:0] mulB;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] minor;
    logic [DATA_WIDTH-1:0] cofVal;
    logic [DATA_WIDTH-1:0] detFinal;

    // Each cofactor occupies two counter steps, so the cofactor number is
    // the counter without its phase bit. During DET the low counter bits
    // pick which top-row term is being accumulated.
    assign cofK   = cnt_q[4:1];
    assign detIdx = cnt_q[1:0];

    matadj3_idx_lut uIdxLut (
        .k_i   (cofK),
        .sel_o (cofSel)
    );

    // Operand steering for the one shared multiplier. Phase 0 of a
    // cofactor forms the leading diagonal product, phase 1 the crossing
    // product; DET multiplies a0c by C0c, which sits at adj element (c,0).
    always_comb begin
        mulA = '0;
        mulB = '0;
        case (state_q)
            COF: begin
                if (!cnt_q[0]) begin
                    mulA = mat_q[cofSel.idxP0];
                    mulB = mat_q[cofSel.idxP1];
                end else begin
                    mulA = mat_q[cofSel.idxQ0];
                    mulB = mat_q[cofSel.idxQ1];
                end
            end
            DET: begin
                mulA = mat_q[elem_idx(2'd0, detIdx)];
                mulB = cof_q[elem_idx(detIdx, 2'd0)];
            end
            default: begin
                mulA = '0;
                mulB = '0;
            end
        endcase
    end

    // The product is deliberately kept at DATA_WIDTH bits; the upper half
    // never matters under modulo arithmetic.
    always_comb begin
        prod     = mulA * mulB;
        minor    = part_q - prod;
        cofVal   = cofSel.neg ? ('0 - minor) : minor;
        detFinal = acc_q + prod;
    end

    // Controller and datapath next-state. The input copy is taken on the
    // accepting edge so the source may change a afterwards. Results only
    // move to the output registers on entry to OUT, so the previous answer
    // stays visible while the next one is being computed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mat_d   = mat_q;
        cof_d   = cof_q;
        adj_d   = adj_q;
        part_d  = part_q;
        acc_d   = acc_q;
        det_d   = det_q;
`ifdef MATADJ3_SINGULAR_EN
        sing_d  = sing_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mat_d   = a;
                    cnt_d   = '0;
                    state_d = COF;
                end
            end
            COF: begin
                if (!cnt_q[0]) begin
                    part_d = prod;
                end else begin
                    cof_d[cofSel.idxDst] = cofVal;
                end
                if (cnt_q == CNT_W'(COF_CYCLES - 1)) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = DET;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DET: begin
                acc_d = detFinal;
                if (cnt_q == CNT_W'(DET_CYCLES - 1)) begin
                    state_d = OUT;
                    det_d   = detFinal;
`ifdef MATADJ3_SINGULAR_EN
                    sing_d  = (detFinal == '0);
                    adj_d   = (detFinal == '0) ? '0 : cof_q;
`else
                    adj_d   = cof_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over any computation in
    // flight and clears the presented result as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mat_q   <= '0;
            cof_q   <= '0;
            adj_q   <= '0;
            part_q  <= '0;
            acc_q   <= '0;
            det_q   <= '0;
`ifdef MATADJ3_SINGULAR_EN
            sing_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat_q   <= mat_d;
            cof_q   <= cof_d;
            adj_q   <= adj_d;
            part_q  <= part_d;
            acc_q   <= acc_d;
            det_q   <= det_d;
`ifdef MATADJ3_SINGULAR_EN
            sing_q  <= sing_d;
`endif
        end
    end

    // Handshake flags come straight from the state; outputs are registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        adj       = adj_q;
        det       = det_q;
`ifdef MATADJ3_SINGULAR_EN
        singular  = sing_q;
`endif
    end

endmodule

// File: tb/tb_matadj3_seq.sv
// tb_matadj3_seq
//   Directed self-checking bench for matadj3_seq with hand-computed
//   adjugates and determinants. Honours MATADJ3_SINGULAR_EN when defined.
module tb_matadj3_seq;

    localparam int DW = 8;
    localparam int MW = 9 * DW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [MW-1:0] a         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [MW-1:0] adj;
    logic [DW-1:0] det;
`ifdef MATADJ3_SINGULAR_EN
    logic          singular;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    matadj3_seq #(
        .DATA_WIDTH  (DW),
        .MATRIX_SIZE (9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .adj       (adj),
        .det       (det)
`ifdef MATADJ3_SINGULAR_EN
        ,
        .singular  (singular)
`endif
    );

    // Pack a matrix given row-major; element (r,c) lands at [(3r+c)*DW].
    function automatic logic [MW-1:0] mat9(
        input logic [DW-1:0] e00, e01, e02,
        input logic [DW-1:0] e10, e11, e12,
        input logic [DW-1:0] e20, e21, e22);
        return {e22, e21, e20, e12, e11, e10, e02, e01, e00};
    endfunction

    logic [MW-1:0] matIdent;
    logic [MW-1:0] matGen;
    logic [MW-1:0] adjGen;

    // Called at the falling edge right after the accepting edge (cycle 1
    // counting the handshake cycle as 0); returns the cycle in which
    // out_valid is first seen, bounded so a dead DUT cannot hang the run.
    task automatic waitOut(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Present one matrix from IDLE, drop in_valid after acceptance and
    // wait for the result.
    task automatic applyStimulus(input logic [MW-1:0] m, output int lat);
        @(negedge clk);
        a        = m;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        waitOut(lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (adj !== '0) $display("FAIL reset_adj: got %h expected 0", adj); else passes++;
        checks++; if (det !== '0) $display("FAIL reset_det: got %h expected 0", det); else passes++;
`ifdef MATADJ3_SINGULAR_EN
        checks++; if (singular !== 1'b0) $display("FAIL reset_singular: got %b expected 0", singular); else passes++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_identity;
        int lat;
        applyStimulus(matIdent, lat);
        checks++; if (lat !== 22) $display("FAIL identity_latency: got %0d expected 22", lat); else passes++;
        checks++; if (adj !== matIdent) $display("FAIL identity_adj: got %h expected %h", adj, matIdent); else passes++;
        checks++; if (det !== 8'h01) $display("FAIL identity_det: got %h expected 01", det); else passes++;
`ifdef MATADJ3_SINGULAR_EN
        checks++; if (singular !== 1'b0) $display("FAIL identity_singular: got %b expected 0", singular); else passes++;
`endif
    endtask

    task automatic test_diag;
        int lat;
        logic [MW-1:0] expAdj;
        expAdj = mat9(8'h0C, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h06);
        applyStimulus(mat9(8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4), lat);
        checks++; if (adj !== expAdj) $display("FAIL diag_adj: got %h expected %h", adj, expAdj); else passes++;
        checks++; if (det !== 8'h18) $display("FAIL diag_det: got %h expected 18", det); else passes++;
    endtask

    task automatic test_singular_matrix;
        int lat;
        logic [MW-1:0] expAdj;
`ifdef MATADJ3_SINGULAR_EN
        expAdj = '0;
`else
        expAdj = mat9(8'hFD, 8'h06, 8'hFD, 8'h06, 8'hF4, 8'h06, 8'hFD, 8'h06, 8'hFD);
`endif
        applyStimulus(mat9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9), lat);
        checks++; if (adj !== expAdj) $display("FAIL seq123_adj: got %h expected %h", adj, expAdj); else passes++;
        checks++; if (det !== 8'h00) $display("FAIL seq123_det: got %h expected 00", det); else passes++;
`ifdef MATADJ3_SINGULAR_EN
        checks++; if (singular !== 1'b1) $display("FAIL seq123_singular: got %b expected 1", singular); else passes++;
`endif
    endtask

    task automatic test_wrap;
        int lat;
        logic [MW-1:0] expAdj;
`ifdef MATADJ3_SINGULAR_EN
        expAdj = '0;
`else
        expAdj = mat9(8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
`endif
        applyStimulus(mat9(8'd16, 8'd0, 8'd0, 8'd0, 8'd16, 8'd0, 8'd0, 8'd0, 8'd1), lat);
        checks++; if (adj !== expAdj) $display("FAIL wrap_adj: got %h expected %h", adj, expAdj); else passes++;
        checks++; if (det !== 8'h00) $display("FAIL wrap_det: got %h expected 00", det); else passes++;
    endtask

    task automatic test_general;
        int lat;
        applyStimulus(matGen, lat);
        checks++; if (adj !== adjGen) $display("FAIL general_adj: got %h expected %h", adj, adjGen); else passes++;
        checks++; if (det !== 8'h01) $display("FAIL general_det: got %h expected 01", det); else passes++;
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        applyStimulus(matGen, lat);
        a        = matIdent;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); else passes++;
            checks++; if (adj !== adjGen) $display("FAIL bp_adj[%0d]: got %h expected %h", i, adj, adjGen); else passes++;
            checks++; if (det !== 8'h01) $display("FAIL bp_det[%0d]: got %h expected 01", i, det); else passes++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_accept_in_ready: got %b expected 0", in_ready); else passes++;
        waitOut(lat);
        checks++; if (lat !== 22) $display("FAIL bp_next_latency: got %0d expected 22", lat); else passes++;
        checks++; if (adj !== matIdent) $display("FAIL bp_next_adj: got %h expected %h", adj, matIdent); else passes++;
    endtask

    task automatic test_reset_mid_cof;
        int lat;
        @(negedge clk);
        a        = matGen;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (adj !== '0) $display("FAIL midrst_adj: got %h expected 0", adj); else passes++;
        checks++; if (det !== '0) $display("FAIL midrst_det: got %h expected 0", det); else passes++;
        rst_n = 1'b1;
        applyStimulus(matIdent, lat);
        checks++; if (lat !== 22) $display("FAIL midrst_latency: got %0d expected 22", lat); else passes++;
        checks++; if (adj !== matIdent) $display("FAIL midrst_adj_after: got %h expected %h", adj, matIdent); else passes++;
        checks++; if (det !== 8'h01) $display("FAIL midrst_det_after: got %h expected 01", det); else passes++;
    endtask

    // The next matrix is offered while the previous result is being taken;
    // it must be accepted exactly one cycle after the output handshake.
    task automatic test_back_to_back;
        int lat;
        out_ready = 1'b1;
        applyStimulus(mat9(8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4), lat);
        a        = matGen;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", in_ready); else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_accepted: got %b expected 0", in_ready); else passes++;
        waitOut(lat);
        checks++; if (lat !== 22) $display("FAIL b2b_latency: got %0d expected 22", lat); else passes++;
        checks++; if (adj !== adjGen) $display("FAIL b2b_adj: got %h expected %h", adj, adjGen); else passes++;
        checks++; if (det !== 8'h01) $display("FAIL b2b_det: got %h expected 01", det); else passes++;
    endtask

    // Hard stop in case a wait escapes its bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run the scenarios in order and report.
    initial begin
        matIdent = mat9(8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1);
        matGen   = mat9(8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd4, 8'd5, 8'd6, 8'd0);
        adjGen   = mat9(8'hE8, 8'h12, 8'h05, 8'h14, 8'hF1, 8'hFC, 8'hFB, 8'h04, 8'h01);
        test_reset;
        test_identity;
        test_diag;
        test_singular_matrix;
        test_wrap;
        test_general;
        test_backpressure;
        test_reset_mid_cof;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
